wb_host_arb: RTL
================

# wb_host_arb

Three-master Wishbone arbiter that shares the single Wishbone slave path into the user core's register/memory fabric between the management SoC port and the two RISC-V core masters (instruction, data). Round-robin grant, bus ownership held for the whole `cyc` burst, and an optional watchdog that terminates transactions the slave never acknowledges. Sits between the external Wishbone slave port and the core interconnect, clocked by the wrapper's Wishbone clock.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `sel` width is `DW/8`
- `TMO_W`, 8, watchdog counter width; timeout limit = `2**TMO_W - 1` cycles
- `clk`  in  1  Wishbone clock; single clock domain
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `mX_cyc_i`, `mX_stb_i`, `mX_we_i`  in  1 each  master X request (X = 0 mgmt SoC, 1 core imem, 2 core dmem)
- `mX_sel_i`  in  DW/8  master X byte select
- `mX_adr_i`  in  AW  master X address
- `mX_dat_i`  in  DW  master X write data
- `mX_dat_o`  out  DW  read data to master X
- `mX_ack_o`, `mX_err_o`  out  1 each  termination to master X
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to slave
- `s_sel_o`  out  DW/8;  `s_adr_o`  out  AW;  `s_dat_o`  out  DW  to slave
- `s_dat_i`  in  DW;  `s_ack_i`, `s_err_i`  in  1 each  from slave
- `gnt_o`  out  2  current owner: 0/1/2, 3 = none

## Operation
- States: IDLE, BUSY, TMO (TMO exists only with watchdog compiled in).
- IDLE: `gnt_o`=3, all slave outputs 0. If any `mX_cyc_i`=1, pick first requester searching from `last+1` mod 3 upward; register `gnt`, go BUSY.
- BUSY: slave outputs = granted master's inputs (combinational mux from registered `gnt`). `s_ack_i`/`s_err_i`/`s_dat_i` routed to granted master only; non-granted masters see `ack`=`err`=0, `dat_o`=0.
- Release: granted master's `cyc_i`=0 sampled at a clock edge → IDLE, `last`←`gnt`. Grant never changes while owner holds `cyc`, regardless of other requests.
- Watchdog (when enabled): counter clears on entering BUSY and on every `s_ack_i` or `s_err_i`; increments each BUSY cycle with `s_stb_o`=1 and no ack/err. On reaching limit: go TMO.
- TMO: `s_cyc_o`=`s_stb_o`=0; owner gets `mX_err_o`=1 for exactly the first TMO cycle; late `s_ack_i`/`s_err_i` ignored. Stay until owner drops `cyc_i`, then IDLE, `last`←`gnt`.
- Simultaneous `s_ack_i` and `s_err_i`: both forwarded unchanged; arbiter does not resolve.
- Owner dropping `cyc_i` in same cycle as ack: normal completion, release at that edge.

## Timing
- Reset values: `gnt`=3, `last`=2 (m0 wins first arbitration), state IDLE, counter 0; every output 0 except `gnt_o`=3.
- Arbitration latency: request seen in IDLE at edge N → slave outputs driven from cycle N+1.
- One dead IDLE cycle between consecutive owners (handover minimum 1 cycle after release edge).
- Ack/err/data return path combinational: zero added latency.
- Timeout: `err` asserted `2**TMO_W - 1` cycles after last ack-free strobe start (255 with defaults).
- `rst_n` low mid-transaction: all outputs forced to reset values immediately, asynchronously; no ack/err generated.

## Configuration
- `WB_ARB_TMO_EN` defined: watchdog counter and TMO state present as above.
- Not defined: no counter, no TMO state; BUSY waits indefinitely for slave termination; `mX_err_o` only ever forwards `s_err_i`.

## Test plan
- After reset, m0 and m2 raise `cyc` same cycle → `gnt_o`=0 next cycle; after m0 releases, one IDLE cycle, then `gnt_o`=2.
- All three request continuously with 1-beat transfers → grant sequence 0,1,2,0,1,2; each master receives exactly one ack per tenure.
- m1 holds `cyc` over 4 back-to-back beats (adr 0x1000..0x100C) while m0 requests → 4 acks to m1, `gnt_o` stays 1, m0 never sees ack.
- m2 read, slave returns `s_dat_i`=0xDEADBEEF with ack → `m2_dat_o`=0xDEADBEEF, `m0_dat_o`=`m1_dat_o`=0.
- `WB_ARB_TMO_EN`, slave never acks m0 → `m0_err_o` single-cycle pulse 255 cycles after strobe, `s_cyc_o` drops; without macro, still waiting after 1000 cycles.
- `rst_n` asserted during m1 BUSY → `s_cyc_o`=0, `gnt_o`=3 without a clock edge; after release m0 wins next arbitration.

Source files
------------

// File: rtl/wb_host_arb.sv
// wb_host_arb: three-master Wishbone arbiter (0 = mgmt SoC, 1 = core imem, 2 = core dmem)
// sharing one slave path. Round-robin grant held for the owner's whole cyc burst.
// Optional watchdog enabled by defining WB_ARB_TMO_EN: aborts transactions the slave never
// terminates after 2**TMO_W - 1 unacknowledged strobe cycles.
module wb_host_arb #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned TMO_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // master 0: management SoC
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    // master 1: core instruction port
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    // master 2: core data port
    input  logic              m2_cyc_i,
    input  logic              m2_stb_i,
    input  logic              m2_we_i,
    input  logic [DW/8-1:0]   m2_sel_i,
    input  logic [AW-1:0]     m2_adr_i,
    input  logic [DW-1:0]     m2_dat_i,
    output logic [DW-1:0]     m2_dat_o,
    output logic              m2_ack_o,
    output logic              m2_err_o,
    // shared slave path
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    // current owner, 3 = none
    output logic [1:0]        gnt_o
);

    localparam int unsigned SW      = DW / 8;
    localparam int unsigned NM      = 3;
    localparam logic [1:0]  GNT_NONE = 2'd3;

`ifdef WB_ARB_TMO_EN
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TMO} state_t;
    localparam logic [TMO_W-1:0] CNT_MAX = '1;
`else
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
`endif

    state_t   state, state_nx;
    logic [1:0] gnt, gnt_nx;
    logic [1:0] last, last_nx;
    logic     owner_cyc;

`ifdef WB_ARB_TMO_EN
    logic [TMO_W-1:0] cnt, cnt_nx;
    logic             tmo_first, tmo_first_nx;
`else
    logic             unused_cfg;
    assign unused_cfg = ^TMO_W;
`endif

    // Per-master views packed into vectors indexed by master number
    logic [NM-1:0]          m_cyc, m_stb, m_we;
    logic [NM-1:0][SW-1:0]  m_sel;
    logic [NM-1:0][AW-1:0]  m_adr;
    logic [NM-1:0][DW-1:0]  m_wdat;
    logic [NM-1:0][DW-1:0]  m_rdat;
    logic [NM-1:0]          m_ack, m_err;

    assign m_cyc  = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
    assign m_stb  = {m2_stb_i, m1_stb_i, m0_stb_i};
    assign m_we   = {m2_we_i,  m1_we_i,  m0_we_i};
    assign m_sel  = {m2_sel_i, m1_sel_i, m0_sel_i};
    assign m_adr  = {m2_adr_i, m1_adr_i, m0_adr_i};
    assign m_wdat = {m2_dat_i, m1_dat_i, m0_dat_i};

    assign m0_dat_o = m_rdat[0];
    assign m1_dat_o = m_rdat[1];
    assign m2_dat_o = m_rdat[2];
    assign m0_ack_o = m_ack[0];
    assign m1_ack_o = m_ack[1];
    assign m2_ack_o = m_ack[2];
    assign m0_err_o = m_err[0];
    assign m1_err_o = m_err[1];
    assign m2_err_o = m_err[2];

    assign gnt_o = gnt;

    // Round-robin pick: first requester searching upward from last+1 (mod 3)
    function automatic logic [1:0] rr_pick(input logic [NM-1:0] req, input logic [1:0] prev);
        logic [1:0] sel;
        int unsigned idx;
        sel = GNT_NONE;
        for (int unsigned i = 1; i <= NM; i++) begin
            idx = (32'(prev) + i) % NM;
            if (sel == GNT_NONE && req[idx]) begin
                sel = 2'(idx);
            end
        end
        return sel;
    endfunction

    // Owner's cyc, used to detect release
    always_comb begin
        owner_cyc = 1'b0;
        case (gnt)
            2'd0:    owner_cyc = m_cyc[0];
            2'd1:    owner_cyc = m_cyc[1];
            2'd2:    owner_cyc = m_cyc[2];
            default: owner_cyc = 1'b0;
        endcase
    end

    // State, grant and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= GNT_NONE;
            last      <= 2'd2;
`ifdef WB_ARB_TMO_EN
            cnt       <= '0;
            tmo_first <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            last      <= last_nx;
`ifdef WB_ARB_TMO_EN
            cnt       <= cnt_nx;
            tmo_first <= tmo_first_nx;
`endif
        end
    end

    // Next-state: arbitrate in IDLE, hold grant until owner drops cyc, watchdog in BUSY
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
`ifdef WB_ARB_TMO_EN
        cnt_nx       = cnt;
        tmo_first_nx = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (|m_cyc) begin
                    gnt_nx   = rr_pick(m_cyc, last);
                    state_nx = ST_BUSY;
`ifdef WB_ARB_TMO_EN
                    cnt_nx   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!owner_cyc) begin
                    state_nx = ST_IDLE;
                    last_nx  = gnt;
                    gnt_nx   = GNT_NONE;
                end
`ifdef WB_ARB_TMO_EN
                else if (s_ack_i || s_err_i) begin
                    cnt_nx = '0;
                end else if (s_stb_o) begin
                    cnt_nx = cnt + TMO_W'(1);
                    if (cnt == CNT_MAX - TMO_W'(1)) begin
                        state_nx     = ST_TMO;
                        tmo_first_nx = 1'b1;
                    end
                end
`endif
            end
`ifdef WB_ARB_TMO_EN
            ST_TMO: begin
                if (!owner_cyc) begin
                    state_nx = ST_IDLE;
                    last_nx  = gnt;
                    gnt_nx   = GNT_NONE;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = GNT_NONE;
            end
        endcase
    end

    // Datapath mux: owner drives the slave, slave response routed back to owner only
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_rdat  = '0;
        m_ack   = '0;
        m_err   = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (gnt == 2'(i)) begin
                if (state == ST_BUSY) begin
                    s_cyc_o   = m_cyc[i];
                    s_stb_o   = m_stb[i];
                    s_we_o    = m_we[i];
                    s_sel_o   = m_sel[i];
                    s_adr_o   = m_adr[i];
                    s_dat_o   = m_wdat[i];
                    m_rdat[i] = s_dat_i;
                    m_ack[i]  = s_ack_i;
                    m_err[i]  = s_err_i;
                end
`ifdef WB_ARB_TMO_EN
                if (state == ST_TMO) begin
                    m_err[i] = tmo_first;
                end
`endif
            end
        end
    end

endmodule
